// File: rtl/cpu_types_pkg.sv
// Shared CPU types: bus word, RAM status encoding and memory-arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter for the single RAM port.
// Optional instruction anti-starvation counter enabled by defining ARB_STARVE_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter word_t       ERR_WORD     = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      err
);

    arb_state_t state, nextState;
    logic       dReq;
    logic       ramDone;
    logic       iComplete;
    logic       dComplete;
    logic       starveGrant;
    word_t      returnWord;

    assign dReq    = dREN | dWEN;
    assign ramDone = (ramstate == ACCESS) || (ramstate == ERROR);

    // A completion needs the grant still held and reset released.
    assign iComplete = (state == IGNT) && iREN && ramDone && nRST;
    assign dComplete = (state == DGNT) && dReq && ramDone && nRST;

    assign returnWord = (ramstate == ERROR) ? ERR_WORD : ramload;

`ifdef ARB_STARVE_EN
    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starveCnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starveCnt <= '0;
        end else if (iComplete) begin
            starveCnt <= '0;
        end else if (dComplete && iREN && (starveCnt != CntW'(STARVE_LIMIT))) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    assign starveGrant = iREN && (starveCnt == CntW'(STARVE_LIMIT));
`else
    assign starveGrant = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (starveGrant) begin
                    nextState = IGNT;
                end else if (dReq) begin
                    nextState = DGNT;
                end else if (iREN) begin
                    nextState = IGNT;
                end
            end
            // Dropping the request aborts; completion also returns to IDLE.
            IGNT: if (!iREN || iComplete) nextState = IDLE;
            DGNT: if (!dReq || dComplete) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= nextState;
            if ((iComplete || dComplete) && (ramstate == ERROR)) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                end
            end
            DGNT: begin
                if (dReq) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                end
            end
            default: ;
        endcase
    end

    assign iwait = iREN & ~iComplete;
    assign dwait = dReq & ~dComplete;
    assign iload = iComplete ? returnWord : '0;
    assign dload = (dComplete && !dWEN) ? returnWord : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a per-requester load-data scoreboard.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    int checks = 0;
    int errors = 0;

    word_t iq[$];
    word_t dq[$];

    int dCnt;
    bit iGranted;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .ERR_WORD    (32'hBAD1BAD1)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic popI();
        if (iq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL iScoreboard observed=unexpected-completion expected=none");
        end else begin
            chk("iload", iload, iq.pop_front());
        end
    endtask

    task automatic popD();
        if (dq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL dScoreboard observed=unexpected-completion expected=none");
        end else begin
            chk("dload", dload, dq.pop_front());
        end
    endtask

    initial begin
        CLK = 1'b0; nRST = 1'b0;
        iREN = 1'b0; iaddr = '0;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        step(); step();

        // Reset state; waits still follow requests.
        iREN = 1'b1;
        #1;
        chk("rstRamREN", ramREN, 0);
        chk("rstRamWEN", ramWEN, 0);
        chk("rstRamaddr", ramaddr, 0);
        chk("rstRamstore", ramstore, 0);
        chk("rstIload", iload, 0);
        chk("rstDload", dload, 0);
        chk("rstErr", err, 0);
        chk("rstIwait", iwait, 1);
        chk("rstDwait", dwait, 0);
        iREN = 1'b0; nRST = 1'b1;
        step();

        // Single instruction read, minimum latency.
        iREN = 1'b1; iaddr = 32'h40; iq.push_back(32'h1234);
        #1;
        chk("t1IdleIwait", iwait, 1);
        chk("t1IdleRamREN", ramREN, 0);
        step();
        ramstate = ACCESS; ramload = 32'h1234;
        #1;
        chk("t1RamREN", ramREN, 1);
        chk("t1Ramaddr", ramaddr, 32'h40);
        chk("t1Iwait", iwait, 0);
        popI();
        step();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("t1BackIdle", ramREN, 0);

        // Simultaneous requests: data first, then instruction after the bubble.
        step();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h80;
        dq.push_back(32'h5555); iq.push_back(32'h6666);
        step();
        #1;
        chk("t2DgntAddr", ramaddr, 32'h80);
        chk("t2DgntREN", ramREN, 1);
        chk("t2DgntDwait", dwait, 1);
        chk("t2DgntIwait", iwait, 1);
        ramstate = ACCESS; ramload = 32'h5555;
        #1;
        chk("t2Dwait", dwait, 0);
        chk("t2IwaitHeld", iwait, 1);
        popD();
        step();
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk("t2BubbleREN", ramREN, 0);
        chk("t2BubbleIwait", iwait, 1);
        step();
        #1;
        chk("t2IgntAddr", ramaddr, 32'h44);
        chk("t2IgntREN", ramREN, 1);
        ramstate = ACCESS; ramload = 32'h6666;
        #1;
        chk("t2Iwait", iwait, 0);
        popI();
        step();
        iREN = 1'b0; ramstate = FREE;

        // Data write with three BUSY cycles.
        step();
        dWEN = 1'b1; dstore = 32'hCAFE; daddr = 32'h100;
        step();
        ramstate = BUSY;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3BusyWEN", ramWEN, 1);
            chk("t3BusyREN", ramREN, 0);
            chk("t3BusyStore", ramstore, 32'hCAFE);
            chk("t3BusyAddr", ramaddr, 32'h100);
            chk("t3BusyDwait", dwait, 1);
            step();
        end
        ramstate = ACCESS; ramload = 32'hFFFF;
        #1;
        chk("t3AccWEN", ramWEN, 1);
        chk("t3AccStore", ramstore, 32'hCAFE);
        chk("t3AccDwait", dwait, 0);
        chk("t3WriteDload", dload, 0);
        step();
        dWEN = 1'b0; ramstate = FREE;
        #1;
        chk("t3DoneWEN", ramWEN, 0);

        // RAM error on a data read; err is sticky.
        step();
        dREN = 1'b1; daddr = 32'h200; dq.push_back(32'hBAD1BAD1);
        step();
        ramstate = ERROR; ramload = 32'h1111;
        #1;
        chk("t4Dwait", dwait, 0);
        chk("t4ErrBeforeEdge", err, 0);
        popD();
        step();
        dREN = 1'b0; ramstate = FREE;
        #1;
        chk("t4ErrSet", err, 1);
        step();
        iREN = 1'b1; iaddr = 32'h48; iq.push_back(32'h7777);
        step();
        ramstate = ACCESS; ramload = 32'h7777;
        #1;
        chk("t4Iwait", iwait, 0);
        popI();
        step();
        iREN = 1'b0; ramstate = FREE;
        #1;
        chk("t4ErrSticky", err, 1);

        // Abort while BUSY.
        step();
        dREN = 1'b1; daddr = 32'h300;
        step();
        ramstate = BUSY;
        #1;
        chk("t5BusyREN", ramREN, 1);
        chk("t5BusyDwait", dwait, 1);
        step();
        dREN = 1'b0;
        #1;
        chk("t5AbortREN", ramREN, 0);
        chk("t5AbortDwait", dwait, 0);
        step();
        ramstate = ACCESS; ramload = 32'h2222;
        #1;
        chk("t5IdleREN", ramREN, 0);
        chk("t5NoDload", dload, 0);
        chk("t5ErrStill", err, 1);
        ramstate = FREE;

        // Reset during an instruction grant.
        step();
        iREN = 1'b1; iaddr = 32'h400;
        step();
        ramstate = BUSY;
        #1;
        chk("t6IgntREN", ramREN, 1);
        chk("t6IgntAddr", ramaddr, 32'h400);
        nRST = 1'b0;
        step();
        chk("t6RstREN", ramREN, 0);
        chk("t6RstAddr", ramaddr, 0);
        chk("t6RstErr", err, 0);
        chk("t6RstIload", iload, 0);
        chk("t6RstIwait", iwait, 1);
        iREN = 1'b0; nRST = 1'b1; ramstate = FREE;
        step();

        // Continuous data traffic with a pending instruction request.
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
        ramstate = ACCESS; ramload = 32'h3333;
        dCnt = 0; iGranted = 1'b0;
        for (int i = 0; i < 50 && !iGranted; i++) begin
            #1;
            if (ramREN && ramaddr == 32'h500) iGranted = 1'b1;
            else if (!dwait) dCnt++;
            step();
        end
`ifdef ARB_STARVE_EN
        chk("starveIGrant", 32'(iGranted), 1);
        chk("starveDataCount", dCnt, 4);
`else
        chk("noIGrant", 32'(iGranted), 0);
        chk("dataCount", dCnt, 25);
`endif
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        step();
        chk("iqDrained", iq.size(), 0);
        chk("dqDrained", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
